// File: rtl/apmu_ibex_if_dummy_insert.sv
// IF/ID slot that merges the dummy-instruction stream with real fetches for the ID stage.
// Optional macro APMU_DUMMY_INSTR_STATS_EN adds a saturating count of inserted dummies.
module apmu_ibex_if_dummy_insert #(
  parameter bit ForwardProgress = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        insert_dummy_instr_i,
  input  logic [31:0] dummy_instr_data_i,
  output logic        fetch_valid_o,
  output logic        id_in_ready_o,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] instr_addr_id_o,
  output logic        instr_fetch_err_o,
  output logic        instr_is_dummy_id_o,
  output logic [15:0] dummy_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    FULL_REAL  = 2'd1,
    FULL_DUMMY = 2'd2
  } slot_e;

  slot_e       state_q, state_d;
  logic [31:0] rdata_p1;
  logic [31:0] addr_p1;
  logic        err_p1;
  logic        last_dummy_q;
  logic [31:0] last_addr_q;

  logic load_en;
  logic block;
  logic accept_dummy;
  logic accept_real;

  assign load_en      = ((state_q == EMPTY) | id_ready_i) & ~flush_i;
  assign block        = ForwardProgress & last_dummy_q & fetch_valid_i;
  assign accept_dummy = insert_dummy_instr_i & load_en & ~block;
  assign accept_real  = fetch_valid_i & load_en & ~accept_dummy;

  assign fetch_ready_o = accept_real;
  assign fetch_valid_o = fetch_valid_i;
  assign id_in_ready_o = load_en & (~insert_dummy_instr_i | accept_dummy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (load_en) begin
      if (accept_dummy)     state_d = FULL_DUMMY;
      else if (accept_real) state_d = FULL_REAL;
      else                  state_d = EMPTY;
    end
  end

  // IF -> ID boundary: slot payload, cleared whenever the slot empties
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_p1 <= 32'h0;
      addr_p1  <= 32'h0;
      err_p1   <= 1'b0;
    end else if (accept_dummy) begin
      rdata_p1 <= dummy_instr_data_i;
      addr_p1  <= fetch_valid_i ? fetch_addr_i : last_addr_q;
      err_p1   <= 1'b0;
    end else if (accept_real) begin
      rdata_p1 <= fetch_rdata_i;
      addr_p1  <= fetch_addr_i;
      err_p1   <= fetch_err_i;
    end else if (flush_i || load_en) begin
      rdata_p1 <= 32'h0;
      addr_p1  <= 32'h0;
      err_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_dummy_q <= 1'b0;
      last_addr_q  <= 32'h0;
    end else begin
      if (accept_dummy)                   last_dummy_q <= 1'b1;
      else if (accept_real || flush_i)    last_dummy_q <= 1'b0;
      if (accept_real)                    last_addr_q  <= fetch_addr_i;
    end
  end

  assign instr_valid_id_o    = (state_q != EMPTY);
  assign instr_is_dummy_id_o = (state_q == FULL_DUMMY);
  assign instr_rdata_id_o    = rdata_p1;
  assign instr_addr_id_o     = addr_p1;
  assign instr_fetch_err_o   = err_p1;

`ifdef APMU_DUMMY_INSTR_STATS_EN
  logic [15:0] dummy_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dummy_cnt_q <= 16'h0;
    end else if (accept_dummy && (dummy_cnt_q != 16'hFFFF)) begin
      dummy_cnt_q <= dummy_cnt_q + 16'h1;
    end
  end

  assign dummy_cnt_o = dummy_cnt_q;
`else
  assign dummy_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_apmu_ibex_if_dummy_insert.sv
// Directed bench for apmu_ibex_if_dummy_insert: real/dummy merging, stalls, flush, errors, reset.
module tb_apmu_ibex_if_dummy_insert;

  logic        clk_i;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_err_i;
  logic        fetch_ready_o;
  logic        insert_dummy_instr_i;
  logic [31:0] dummy_instr_data_i;
  logic        fetch_valid_o;
  logic        id_in_ready_o;
  logic        flush_i;
  logic        id_ready_i;
  logic        instr_valid_id_o;
  logic [31:0] instr_rdata_id_o;
  logic [31:0] instr_addr_id_o;
  logic        instr_fetch_err_o;
  logic        instr_is_dummy_id_o;
  logic [15:0] dummy_cnt_o;

  int checks = 0;
  int errors = 0;

  apmu_ibex_if_dummy_insert #(.ForwardProgress(1'b1)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_rdata_i       (fetch_rdata_i),
    .fetch_addr_i        (fetch_addr_i),
    .fetch_err_i         (fetch_err_i),
    .fetch_ready_o       (fetch_ready_o),
    .insert_dummy_instr_i(insert_dummy_instr_i),
    .dummy_instr_data_i  (dummy_instr_data_i),
    .fetch_valid_o       (fetch_valid_o),
    .id_in_ready_o       (id_in_ready_o),
    .flush_i             (flush_i),
    .id_ready_i          (id_ready_i),
    .instr_valid_id_o    (instr_valid_id_o),
    .instr_rdata_id_o    (instr_rdata_id_o),
    .instr_addr_id_o     (instr_addr_id_o),
    .instr_fetch_err_o   (instr_fetch_err_o),
    .instr_is_dummy_id_o (instr_is_dummy_id_o),
    .dummy_cnt_o         (dummy_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] d,
                          input logic [31:0] a, input logic e, input logic dm);
    chk1 ({tag, "_valid"}, instr_valid_id_o, v);
    chk32({tag, "_rdata"}, instr_rdata_id_o, d);
    chk32({tag, "_addr"},  instr_addr_id_o, a);
    chk1 ({tag, "_err"},   instr_fetch_err_o, e);
    chk1 ({tag, "_dummy"}, instr_is_dummy_id_o, dm);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'h0;
    fetch_addr_i = 32'h0;
    fetch_err_i = 1'b0;
    insert_dummy_instr_i = 1'b0;
    dummy_instr_data_i = 32'h0;
    flush_i = 1'b0;
    id_ready_i = 1'b1;
    tick();
    tick();

    // reset state
    chk_slot("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk32("rst_cnt", {16'h0, dummy_cnt_o}, 32'h0);
    chk1("rst_fetch_ready", fetch_ready_o, 1'b0);
    chk1("rst_id_in_ready", id_in_ready_o, 1'b1);
    rst_ni = 1'b1;
    tick();

    // plain real fetch
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00000013; fetch_addr_i = 32'h100;
    #1;
    chk1("r1_fetch_ready", fetch_ready_o, 1'b1);
    chk1("r1_fetch_valid_o", fetch_valid_o, 1'b1);
    tick();
    chk_slot("r1", 1'b1, 32'h13, 32'h100, 1'b0, 1'b0);

    // dummy wins over a valid fetch and takes its PC
    insert_dummy_instr_i = 1'b1; dummy_instr_data_i = 32'h00A50033;
    fetch_addr_i = 32'h200;
    #1;
    chk1("d1_fetch_ready", fetch_ready_o, 1'b0);
    chk1("d1_id_in_ready", id_in_ready_o, 1'b1);
    tick();
    chk_slot("d1", 1'b1, 32'h00A50033, 32'h200, 1'b0, 1'b1);

    // forward progress: real instruction goes next even with request held
    #1;
    chk1("fp1_fetch_ready", fetch_ready_o, 1'b1);
    chk1("fp1_id_in_ready", id_in_ready_o, 1'b0);
    tick();
    chk_slot("fp1", 1'b1, 32'h13, 32'h200, 1'b0, 1'b0);

    fetch_rdata_i = 32'h00000093; fetch_addr_i = 32'h204;
    #1;
    chk1("d2_id_in_ready", id_in_ready_o, 1'b1);
    tick();
    chk_slot("d2", 1'b1, 32'h00A50033, 32'h204, 1'b0, 1'b1);
    #1;
    chk1("fp2_id_in_ready", id_in_ready_o, 1'b0);
    tick();
    chk_slot("fp2", 1'b1, 32'h93, 32'h204, 1'b0, 1'b0);

    // ID stall for three cycles holds the slot
    insert_dummy_instr_i = 1'b0; id_ready_i = 1'b0;
    fetch_rdata_i = 32'h00000113; fetch_addr_i = 32'h208;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("stall_fetch_ready", fetch_ready_o, 1'b0);
      chk1("stall_id_in_ready", id_in_ready_o, 1'b0);
      tick();
      chk_slot("stall", 1'b1, 32'h93, 32'h204, 1'b0, 1'b0);
    end
    id_ready_i = 1'b1;
    tick();
    chk_slot("unstall", 1'b1, 32'h113, 32'h208, 1'b0, 1'b0);

    // dummy without fetch reuses the last real PC
    fetch_valid_i = 1'b0; insert_dummy_instr_i = 1'b1; dummy_instr_data_i = 32'h00B60033;
    tick();
    chk_slot("d3", 1'b1, 32'h00B60033, 32'h208, 1'b0, 1'b1);

    // flush with a pending dummy request: not consumed
    flush_i = 1'b1; dummy_instr_data_i = 32'h00C70033;
    #1;
    chk1("fl_fetch_ready", fetch_ready_o, 1'b0);
    chk1("fl_id_in_ready", id_in_ready_o, 1'b0);
    tick();
    chk1("fl_valid", instr_valid_id_o, 1'b0);
    chk1("fl_dummy", instr_is_dummy_id_o, 1'b0);
    flush_i = 1'b0;
    #1;
    chk1("postfl_id_in_ready", id_in_ready_o, 1'b1);
    tick();
    chk_slot("d4", 1'b1, 32'h00C70033, 32'h208, 1'b0, 1'b1);

    // fetch error after a dummy
    insert_dummy_instr_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00000193; fetch_addr_i = 32'h300; fetch_err_i = 1'b1;
    tick();
    chk_slot("err", 1'b1, 32'h193, 32'h300, 1'b1, 1'b0);
`ifdef APMU_DUMMY_INSTR_STATS_EN
    chk32("cnt", {16'h0, dummy_cnt_o}, 32'd4);
`else
    chk32("cnt", {16'h0, dummy_cnt_o}, 32'd0);
`endif

    // nothing offered: slot empties
    fetch_valid_i = 1'b0; fetch_err_i = 1'b0;
    tick();
    chk1("empty_valid", instr_valid_id_o, 1'b0);

    // asynchronous reset mid-transfer
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00000213; fetch_addr_i = 32'h400;
    tick();
    chk_slot("pre_arst", 1'b1, 32'h213, 32'h400, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_slot("arst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    fetch_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
